// File: rtl/spike_rate_decoder_if.sv
// ----------------------------------------------------------------------------
// spike_rate_decoder_if
//   Result/handshake bundle between the spike rate decoder and downstream
//   control logic.
//
//   out_valid  decoder -> consumer  decoded result available
//   out_ready  consumer -> decoder  result accepted (transfer = valid & ready)
//   win_idx    decoder -> consumer  index of the most active channel
//   win_count  decoder -> consumer  spike count of the winning channel
//   tie        decoder -> consumer  another channel matches win_count
//   overrun    decoder -> consumer  sticky: a window result was dropped
//   all_counts decoder -> consumer  snapshot of every channel, ch0 in LSBs
//                                   (present only when SPIKE_DEC_COUNTS_EN
//                                   is defined)
//
//   Modports: master = decoder side, slave = consumer side.
// ----------------------------------------------------------------------------
interface spike_rate_decoder_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] win_idx;
    logic [CNT_W-1:0] win_count;
    logic             tie;
    logic             overrun;
`ifdef SPIKE_DEC_COUNTS_EN
    logic [N_CH*CNT_W-1:0] all_counts;

    modport master (
        output out_valid, win_idx, win_count, tie, overrun, all_counts,
        input  out_ready
    );
    modport slave (
        input  out_valid, win_idx, win_count, tie, overrun, all_counts,
        output out_ready
    );
`else
    modport master (
        output out_valid, win_idx, win_count, tie, overrun,
        input  out_ready
    );
    modport slave (
        input  out_valid, win_idx, win_count, tie, overrun,
        output out_ready
    );
`endif
endinterface

// File: rtl/spike_rate_decoder.sv
// ----------------------------------------------------------------------------
// spike_rate_decoder
//   Counts spikes of N_CH output neurons over windows of T_WINDOW enabled
//   cycles, then picks the most active channel (lowest index wins ties) and
//   presents the result over a valid/ready handshake. Live counters and the
//   snapshot used by the scan are separate, so accumulation never pauses.
//
//   Ports
//     clk     clock
//     rst     synchronous active-high reset
//     en      sample enable (gates window counter and accumulation only)
//     spikes  one spike bit per channel
//     bus     spike_rate_decoder_if.master (result + handshake + overrun)
//
//   Optional build macro: SPIKE_DEC_COUNTS_EN adds bus.all_counts carrying
//   the snapshot counts; decode results and timing do not depend on it.
// ----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int N_CH     = 4,
    parameter int T_WINDOW = 250,
    parameter int CNT_W    = 8,
    parameter int IDX_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_CH-1:0]        spikes,
    spike_rate_decoder_if.master   bus
);
    localparam int WIN_W = $clog2(T_WINDOW);
    localparam int PTR_W = $clog2(N_CH + 1);
    localparam int SEL_W = $clog2(N_CH);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(T_WINDOW - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_CH);

    localparam logic [1:0] SCAN_IDLE = 2'd0;
    localparam logic [1:0] SCAN      = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] live_cnt_q [N_CH];
    logic [CNT_W-1:0] live_cnt_d [N_CH];
    logic [CNT_W-1:0] live_inc   [N_CH];
    logic [CNT_W-1:0] snap_q     [N_CH];
    logic [CNT_W-1:0] snap_d     [N_CH];

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tie_q, tie_d;
    logic             overrun_q, overrun_d;

    logic win_close;
    logic transfer;
    logic snap_load;

    assign win_close = en && (win_cnt_q == WIN_LAST);
    assign transfer  = (state_q == HOLD) && bus.out_ready;
    // A closing window is only captured when the scan engine is free (idle,
    // or releasing its held result on this very edge); otherwise it is lost.
    assign snap_load = win_close && ((state_q == SCAN_IDLE) || transfer);

    // Saturating per-channel increment, shared by accumulation and snapshot.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_inc
            assign live_inc[gi] = (spikes[gi] && (live_cnt_q[gi] != CNT_MAX))
                                ? live_cnt_q[gi] + CNT_W'(1) : live_cnt_q[gi];
        end
    endgenerate

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (win_close)
            win_cnt_d = '0;
        else if (en)
            win_cnt_d = win_cnt_q + WIN_W'(1);

        for (int i = 0; i < N_CH; i++) begin
            live_cnt_d[i] = live_cnt_q[i];
            snap_d[i]     = snap_q[i];
            if (win_close)
                live_cnt_d[i] = '0;
            else if (en)
                live_cnt_d[i] = live_inc[i];
            if (snap_load)
                snap_d[i] = live_inc[i];
        end
    end

    // Scan is pipelined through rd_q (registered read of snap): ptr runs
    // 0..N_CH, reading channel ptr while comparing channel ptr-1. This makes
    // the scan N_CH+1 cycles long.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rd_d      = rd_q;
        max_d     = max_q;
        idx_d     = idx_q;
        tie_d     = tie_q;
        overrun_d = overrun_q | (win_close & ~snap_load);

        case (state_q)
            SCAN_IDLE: begin
                if (snap_load) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                    rd_d    = '0;
                    max_d   = '0;
                    idx_d   = '0;
                    tie_d   = 1'b0;
                end
            end
            SCAN: begin
                if (ptr_q != PTR_LAST)
                    rd_d = snap_q[SEL_W'(ptr_q)];
                if (ptr_q != '0) begin
                    if (rd_q > max_q) begin
                        max_d = rd_q;
                        idx_d = IDX_W'(ptr_q - PTR_W'(1));
                        tie_d = 1'b0;
                    end else if ((rd_q == max_q) && (ptr_q != PTR_W'(1))) begin
                        tie_d = 1'b1;
                    end
                end
                if (ptr_q == PTR_LAST)
                    state_d = HOLD;
                else
                    ptr_d = ptr_q + PTR_W'(1);
            end
            HOLD: begin
                if (transfer) begin
                    if (snap_load) begin
                        state_d = SCAN;
                        ptr_d   = '0;
                        rd_d    = '0;
                        max_d   = '0;
                        idx_d   = '0;
                        tie_d   = 1'b0;
                    end else begin
                        state_d = SCAN_IDLE;
                    end
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                live_cnt_q[i] <= '0;
                snap_q[i]     <= '0;
            end
            state_q   <= SCAN_IDLE;
            ptr_q     <= '0;
            rd_q      <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            tie_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            for (int i = 0; i < N_CH; i++) begin
                live_cnt_q[i] <= live_cnt_d[i];
                snap_q[i]     <= snap_d[i];
            end
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rd_q      <= rd_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            tie_q     <= tie_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.win_idx   = idx_q;
    assign bus.win_count = max_q;
    assign bus.tie       = tie_q;
    assign bus.overrun   = overrun_q;

`ifdef SPIKE_DEC_COUNTS_EN
    // snap only changes at scan entry, so it is already stable through HOLD.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_all
            assign bus.all_counts[gi*CNT_W +: CNT_W] = snap_q[gi];
        end
    endgenerate
`endif

endmodule
